// File: rtl/complex_accumulator.sv
// complex_accumulator: sums a stream of signed complex products into one complex
// accumulation per frame. A frame ends on in_last or after MAX_LEN beats. The
// result is then held on a valid/ready handshake until it is taken, and no input
// is accepted in the meantime.
//
// Parameters: IW (input width per component), GUARD (extra accumulator bits,
// OW = IW + GUARD), MAX_LEN (max beats per frame, CW = $clog2(MAX_LEN + 1)).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   ce                  clock enable; low freezes all state and blocks transfers
//   in_valid/in_ready   input beat handshake; in_real/in_imag/in_last payload
//   out_valid/out_ready result handshake
//   acc_real/acc_imag   OW-bit signed sums; acc_count beats in the frame
//   overflow            sticky per frame: a component left the OW-bit range
//
// Build option: define COMPLEX_ACC_SATURATE_EN to clamp a component on overflow
// (it then stays clamped for the rest of the frame) instead of wrapping.
module complex_accumulator #(
  parameter int unsigned IW      = 19,
  parameter int unsigned GUARD   = 8,
  parameter int unsigned MAX_LEN = 256
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ce,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [IW-1:0]              in_real,
  input  logic signed [IW-1:0]              in_imag,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [IW+GUARD-1:0]        acc_real,
  output logic signed [IW+GUARD-1:0]        acc_imag,
  output logic [$clog2(MAX_LEN+1)-1:0]      acc_count,
  output logic                              overflow
);

  localparam int unsigned OW = IW + GUARD;
  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_LEN);

  typedef enum logic [0:0] {StAcc, StDone} state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] acc_re_q, acc_re_d;
  logic [OW-1:0] acc_im_q, acc_im_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic [OW-1:0] ext_re, ext_im;
  logic [OW:0]   sum_re, sum_im;
  logic          ovf_re, ovf_im;
  logic [OW-1:0] beat_re, beat_im;
  logic [CW-1:0] cnt_inc;

`ifdef COMPLEX_ACC_SATURATE_EN
  localparam logic [OW-1:0] PosMax = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] NegMin = {1'b1, {(OW-1){1'b0}}};

  // Per-component "clamped" flags; a clamped component ignores later beats.
  logic sat_re_q, sat_re_d;
  logic sat_im_q, sat_im_d;
`endif

  always_comb begin
    ext_re  = {{GUARD{in_real[IW-1]}}, in_real};
    ext_im  = {{GUARD{in_imag[IW-1]}}, in_imag};
    // One extra bit: overflow is the carry into vs out of the OW-bit sign bit,
    // i.e. the two top bits of the widened sum disagree.
    sum_re  = {acc_re_q[OW-1], acc_re_q} + {ext_re[OW-1], ext_re};
    sum_im  = {acc_im_q[OW-1], acc_im_q} + {ext_im[OW-1], ext_im};
    ovf_re  = sum_re[OW] ^ sum_re[OW-1];
    ovf_im  = sum_im[OW] ^ sum_im[OW-1];
    cnt_inc = cnt_q + CW'(1);
`ifdef COMPLEX_ACC_SATURATE_EN
    // sum[OW] is the sign of the true sum and selects the clamp direction.
    if (sat_re_q)    beat_re = acc_re_q;
    else if (ovf_re) beat_re = sum_re[OW] ? NegMin : PosMax;
    else             beat_re = sum_re[OW-1:0];
    if (sat_im_q)    beat_im = acc_im_q;
    else if (ovf_im) beat_im = sum_im[OW] ? NegMin : PosMax;
    else             beat_im = sum_im[OW-1:0];
`else
    beat_re = sum_re[OW-1:0];
    beat_im = sum_im[OW-1:0];
`endif
  end

  always_comb begin
    state_d  = state_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
`ifdef COMPLEX_ACC_SATURATE_EN
    sat_re_d = sat_re_q;
    sat_im_d = sat_im_q;
`endif
    if (ce) begin
      unique case (state_q)
        StAcc: begin
          if (in_valid) begin
            acc_re_d = beat_re;
            acc_im_d = beat_im;
            cnt_d    = cnt_inc;
            ovf_d    = ovf_q | ovf_re | ovf_im;
`ifdef COMPLEX_ACC_SATURATE_EN
            sat_re_d = sat_re_q | ovf_re;
            sat_im_d = sat_im_q | ovf_im;
`endif
            if (in_last || (cnt_inc == MaxCnt)) state_d = StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            acc_re_d = '0;
            acc_im_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
`ifdef COMPLEX_ACC_SATURATE_EN
            sat_re_d = 1'b0;
            sat_im_d = 1'b0;
`endif
            state_d  = StAcc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StAcc;
      acc_re_q <= '0;
      acc_im_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef COMPLEX_ACC_SATURATE_EN
      sat_re_q <= 1'b0;
      sat_im_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
`ifdef COMPLEX_ACC_SATURATE_EN
      sat_re_q <= sat_re_d;
      sat_im_q <= sat_im_d;
`endif
    end
  end

  always_comb begin
    in_ready  = ce & (state_q == StAcc);
    out_valid = (state_q == StDone);
    acc_real  = acc_re_q;
    acc_imag  = acc_im_q;
    acc_count = cnt_q;
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_complex_accumulator.sv
module tb_complex_accumulator;

  localparam int IW  = 19;
  // Instance A: narrow guard to reach overflow easily, MAX_LEN 8.
  localparam int GA  = 2;
  localparam int LA  = 8;
  localparam int OWA = IW + GA;
  localparam int CWA = $clog2(LA + 1);
  // Instance B: MAX_LEN 4 for frame-length termination.
  localparam int GB  = 8;
  localparam int LB  = 4;
  localparam int OWB = IW + GB;
  localparam int CWB = $clog2(LB + 1);

  localparam longint MAXV = (64'sd1 <<< (OWA - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (OWA - 1));
  localparam longint SPAN = 64'sd1 <<< OWA;

  logic clk, reset, ce, in_valid, in_last, out_ready;
  logic signed [IW-1:0] in_real, in_imag;

  logic in_ready_a, out_valid_a, overflow_a;
  logic signed [OWA-1:0] acc_real_a, acc_imag_a;
  logic [CWA-1:0] acc_count_a;

  logic in_ready_b, out_valid_b, overflow_b;
  logic signed [OWB-1:0] acc_real_b, acc_imag_b;
  logic [CWB-1:0] acc_count_b;

  complex_accumulator #(.IW(IW), .GUARD(GA), .MAX_LEN(LA)) u_dut_a (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_real(in_real), .in_imag(in_imag), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .acc_real(acc_real_a), .acc_imag(acc_imag_a),
    .acc_count(acc_count_a), .overflow(overflow_a)
  );

  complex_accumulator #(.IW(IW), .GUARD(GB), .MAX_LEN(LB)) u_dut_b (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_real(in_real), .in_imag(in_imag), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .acc_real(acc_real_b), .acc_imag(acc_imag_b),
    .acc_count(acc_count_b), .overflow(overflow_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int re, input int im, input bit last);
    in_valid = v;
    in_real  = IW'(re);
    in_imag  = IW'(im);
    in_last  = last;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    ce        = 1'b1;
    out_ready = 1'b1;
    drive(0, 0, 0, 0);
    step();
    reset = 1'b0;
  endtask

  task automatic chk_a(input string tag, input longint re, input longint im,
                       input longint cnt, input bit ov);
    chk({tag, ".out_valid"}, longint'(out_valid_a), 1);
    chk({tag, ".acc_real"}, longint'(acc_real_a), re);
    chk({tag, ".acc_imag"}, longint'(acc_imag_a), im);
    chk({tag, ".acc_count"}, longint'(acc_count_a), cnt);
    chk({tag, ".overflow"}, longint'(overflow_a), longint'(ov));
  endtask

  // Reference: exact arithmetic on a range-limited value; wrap or clamp on exit.
  task automatic m_add(inout longint acc, inout bit sat, inout bit ov, input longint x);
    longint s;
    if (sat) return;
    s = acc + x;
    if (s > MAXV || s < MINV) begin
      ov = 1'b1;
`ifdef COMPLEX_ACC_SATURATE_EN
      acc = (s > MAXV) ? MAXV : MINV;
      sat = 1'b1;
`else
      acc = (s > MAXV) ? s - SPAN : s + SPAN;
`endif
    end else begin
      acc = s;
    end
  endtask

  typedef struct {
    int re; int im; bit last;
    bit exp_v; int exp_re; int exp_im; int exp_cnt; bit exp_ov;
  } vec_t;

  vec_t   tbl[7];
  longint m_re, m_im;
  int     m_cnt, r_re, r_im;
  bit     m_ov, m_done, m_sre, m_sim;

  initial begin
    tbl[0] = '{1, 2, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{3, -4, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{-5, 6, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{7, 8, 1, 1, 6, 12, 4, 0};
    tbl[4] = '{10, -10, 1, 1, 10, -10, 1, 0};
    tbl[5] = '{-100000, 50000, 0, 0, 0, 0, 0, 0};
    tbl[6] = '{-200000, -50000, 1, 1, -300000, 0, 2, 0};

    // Reset state
    do_reset();
    chk("rst.in_ready", longint'(in_ready_a), 1);
    chk("rst.out_valid", longint'(out_valid_a), 0);
    chk("rst.acc_real", longint'(acc_real_a), 0);
    chk("rst.acc_imag", longint'(acc_imag_a), 0);
    chk("rst.acc_count", longint'(acc_count_a), 0);
    chk("rst.overflow", longint'(overflow_a), 0);

    // Table-driven frames, out_ready held high
    for (int i = 0; i < 7; i++) begin
      chk("tbl.in_ready", longint'(in_ready_a), 1);
      drive(1, tbl[i].re, tbl[i].im, tbl[i].last);
      step();
      drive(0, 0, 0, 0);
      chk("tbl.out_valid", longint'(out_valid_a), longint'(tbl[i].exp_v));
      if (tbl[i].exp_v) begin
        chk_a("tbl", tbl[i].exp_re, tbl[i].exp_im, tbl[i].exp_cnt, tbl[i].exp_ov);
        chk("tbl.done_in_ready", longint'(in_ready_a), 0);
        step();
        chk("tbl.handoff_in_ready", longint'(in_ready_a), 1);
        chk("tbl.handoff_out_valid", longint'(out_valid_a), 0);
      end
    end

    // Back-pressure: result held while out_ready low, pending beat not taken
    do_reset();
    out_ready = 1'b0;
    drive(1, 3, 4, 1);
    step();
    drive(1, 10, -10, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp.in_ready", longint'(in_ready_a), 0);
      chk_a("bp.hold", 3, 4, 1, 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp.after_in_ready", longint'(in_ready_a), 1);
    chk("bp.after_out_valid", longint'(out_valid_a), 0);
    step();
    drive(0, 0, 0, 0);
    chk_a("bp.next", 10, -10, 1, 0);
    step();

    // MAX_LEN termination on instance B, 6 beats without in_last
    do_reset();
    drive(1, 1, 1, 0);
    repeat (4) step();
    chk("len.out_valid", longint'(out_valid_b), 1);
    chk("len.acc_real", longint'(acc_real_b), 4);
    chk("len.acc_imag", longint'(acc_imag_b), 4);
    chk("len.acc_count", longint'(acc_count_b), 4);
    chk("len.in_ready", longint'(in_ready_b), 0);
    step();
    chk("len.handoff_in_ready", longint'(in_ready_b), 1);
    repeat (2) step();
    drive(1, 0, 0, 1);
    step();
    drive(0, 0, 0, 0);
    chk("len2.out_valid", longint'(out_valid_b), 1);
    chk("len2.acc_real", longint'(acc_real_b), 2);
    chk("len2.acc_imag", longint'(acc_imag_b), 2);
    chk("len2.acc_count", longint'(acc_count_b), 3);
    step();

    // Overflow on the 5th of five max-positive beats
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 262143, 0, i == 4);
      step();
    end
    drive(0, 0, 0, 0);
`ifdef COMPLEX_ACC_SATURATE_EN
    chk_a("ovf", 1048575, 0, 5, 1);
`else
    chk_a("ovf", -786437, 0, 5, 1);
`endif
    step();
    chk("ovf.cleared", longint'(overflow_a), 0);

    // ce low mid-frame and during DONE
    do_reset();
    drive(1, 1, 1, 0);
    step();
    drive(1, 2, 2, 0);
    step();
    drive(1, 3, 3, 0);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ce.in_ready", longint'(in_ready_a), 0);
      chk("ce.out_valid", longint'(out_valid_a), 0);
    end
    ce = 1'b1;
    step();
    drive(1, 4, 4, 1);
    step();
    drive(0, 0, 0, 0);
    chk_a("ce.result", 10, 10, 4, 0);
    ce = 1'b0;
    repeat (2) begin
      step();
      chk_a("ce.done_hold", 10, 10, 4, 0);
    end
    ce = 1'b1;
    step();
    chk("ce.handoff_in_ready", longint'(in_ready_a), 1);

    // Reset mid-frame (with ce low: reset wins)
    do_reset();
    drive(1, 7, 7, 0);
    repeat (2) step();
    drive(0, 0, 0, 0);
    reset = 1'b1;
    ce    = 1'b0;
    step();
    reset = 1'b0;
    ce    = 1'b1;
    #1;
    chk("mrst.in_ready", longint'(in_ready_a), 1);
    chk("mrst.out_valid", longint'(out_valid_a), 0);
    chk("mrst.acc_real", longint'(acc_real_a), 0);
    chk("mrst.acc_imag", longint'(acc_imag_a), 0);
    chk("mrst.acc_count", longint'(acc_count_a), 0);
    chk("mrst.overflow", longint'(overflow_a), 0);
    drive(1, 5, 5, 1);
    step();
    drive(0, 0, 0, 0);
    chk_a("mrst.fresh", 5, 5, 1, 0);
    step();

    // Randomized handshakes against the reference model
    do_reset();
    m_re = 0; m_im = 0; m_cnt = 0; m_ov = 0; m_done = 0; m_sre = 0; m_sim = 0;
    for (int c = 0; c < 1500; c++) begin
      ce        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      r_re      = int'($urandom_range(0, 524287)) - 262144;
      r_im      = int'($urandom_range(0, 524287)) - 262144;
      drive($urandom_range(0, 2) != 0, r_re, r_im, $urandom_range(0, 4) == 0);
      #1;
      chk("rnd.in_ready", longint'(in_ready_a), longint'(ce && !m_done));
      chk("rnd.out_valid", longint'(out_valid_a), longint'(m_done));
      if (m_done) chk_a("rnd", m_re, m_im, m_cnt, m_ov);
      if (ce) begin
        if (!m_done && in_valid) begin
          m_add(m_re, m_sre, m_ov, longint'(r_re));
          m_add(m_im, m_sim, m_ov, longint'(r_im));
          m_cnt++;
          if (in_last || m_cnt == LA) m_done = 1'b1;
        end else if (m_done && out_ready) begin
          m_re = 0; m_im = 0; m_cnt = 0; m_ov = 0; m_done = 0; m_sre = 0; m_sim = 0;
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
